// File: rtl/chunked_wide_adder_if.sv
// Operand/result bundle between a requester and the chunked wide adder.
// The master side issues start/sub/a/b; the slave side returns status and result.
// No flow-control beyond start/busy/done; start is only honoured when not busy.
interface chunked_wide_adder_if #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
);
  localparam int N = WIDTH * CHUNKS;

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/chunked_wide_adder.sv
// Wide add/subtract built from one WIDTH-bit adder stepped over CHUNKS chunks.
// Latency: CHUNKS cycles from accept to the one-cycle done pulse.
// Backpressure: start is ignored while busy; no queueing of requests.
module chunked_wide_adder #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_wide_adder_if.slave   bus
);
  localparam int N     = WIDTH * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_sub;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_acc;
  logic [N-1:0]       r_result;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_chunk;
  logic [WIDTH-1:0]   w_b_chunk;
  logic [WIDTH-1:0]   w_b_op;
  logic [WIDTH-1:0]   w_s;
  logic               w_prev_cout;
  logic               w_cout;
  logic [N-1:0]       w_acc_nxt;

  // A request is taken only when the sequencer is not mid-operation.
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == IDX_W'(CHUNKS - 1));

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign w_b_op   = w_b_chunk ^ {WIDTH{r_sub}};

  // Select the current chunk of each operand and merge the adder sum into the accumulator.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    w_acc_nxt = r_acc;
    for (int k = 0; k < CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_chunk                   = r_a[k*WIDTH +: WIDTH];
        w_b_chunk                   = r_b[k*WIDTH +: WIDTH];
        w_acc_nxt[k*WIDTH +: WIDTH] = w_s;
      end
    end
  end

  behavioral_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .A         (w_a_chunk),
    .B         (w_b_op),
    .cin       (r_carry),
    .S         (w_s),
    .prev_cout (w_prev_cout),
    .cout      (w_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: RUN lasts until the last chunk has been added.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, chunk stepping and carry chain; visible outputs update only on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sub   <= bus.sub;
      r_idx   <= '0;
      r_carry <= bus.sub;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_cout;
      if (w_last) begin
        r_idx    <= '0;
        r_result <= w_acc_nxt;
        r_cout   <= w_cout;
        r_ovf    <= w_prev_cout ^ w_cout;
        r_zero   <= (w_acc_nxt == '0);
      end else begin
        r_idx    <= r_idx + IDX_W'(1);
      end
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// WIDTH-bit ripple adder exposing the carry into the MSB for signed overflow detection.
// Latency: combinational.
// Backpressure: none.
module behavioral_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             prev_cout,
  output logic             cout
);
  logic [WIDTH-1:0] w_low;
  logic [1:0]       w_top;

  // Lower WIDTH-1 bits first so the carry into the sign bit is visible on its own.
  assign w_low     = {1'b0, A[WIDTH-2:0]} + {1'b0, B[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
  assign prev_cout = w_low[WIDTH-1];
  assign w_top     = {1'b0, A[WIDTH-1]} + {1'b0, B[WIDTH-1]} + {1'b0, prev_cout};
  assign S         = {w_top[0], w_low[WIDTH-2:0]};
  assign cout      = w_top[1];
endmodule

// File: doc/chunked_wide_adder.md
# chunked_wide_adder

Multi-cycle wide add/subtract sequencer that drives the team's WIDTH-bit `behavioral_adder` (ports A, B, cin -> S, prev_cout, cout) one WIDTH-bit chunk per cycle. It latches two CHUNKS*WIDTH-bit operands and propagates carry between chunks through a register. It assembles the full result and derives carry, signed overflow and zero flags from the final chunk. The block sits directly upstream of that adder and also consumes its outputs, letting the datapath reach arbitrary widths with one narrow adder.

## Interface
- WIDTH, 8, chunk width in bits; must be >= 2.
- CHUNKS, 4, number of chunks; must be >= 1. Total operand width N = WIDTH*CHUNKS.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a-b; latched with the operands.
- a  in  N  operand A, latched on the accepting edge.
- b  in  N  operand B, latched on the accepting edge.
- busy  out  1  high in RUN only.
- done  out  1  one-cycle pulse in DONE.
- result  out  N  sum or difference; holds until the next DONE.
- carry_out  out  1  cout of the top chunk. For sub, 1 = no borrow.
- overflow  out  1  signed overflow = prev_cout XOR cout of the top chunk.
- zero  out  1  result == 0.

## Operation
- Reset (async, rst=1): state IDLE, chunk index 0, carry register 0, operand/result registers 0. busy, done, result, carry_out, overflow and zero all read 0.
- FSM states and transitions:
  - IDLE: start=1 -> RUN.
  - RUN: stays for exactly CHUNKS cycles, then -> DONE.
  - DONE: start=1 -> RUN; otherwise -> IDLE.
- Accepting edge (start=1 in IDLE or DONE):
  - Latch a, b and sub.
  - Chunk index <= 0; carry register <= sub.
  - Clear the result accumulator.
- RUN, chunk k = index:
  - Adder inputs: A = a[k*WIDTH +: WIDTH], B = b[k*WIDTH +: WIDTH] XOR {WIDTH{sub}}, cin = carry register.
  - On the edge: result[k*WIDTH +: WIDTH] <= S; carry register <= cout; index increments.
- Last chunk (k = CHUNKS-1), same edge:
  - carry_out <= cout.
  - overflow <= prev_cout XOR cout.
  - zero <= (assembled result including this chunk's S) == 0.
  - State -> DONE.
- Arithmetic: modulo 2^N, two's complement. There is no carry-in from outside.
- start in RUN is ignored; there is no queueing.
- Flags and result change only on the last-chunk edge or on reset. A new accept does not clear visible outputs until its own last chunk. result, carry_out and overflow stay stable throughout RUN.
- Reset mid-RUN: abort immediately, all outputs to 0, no done pulse.

## Timing
- Accepting edge t0: busy=1 from t0.
- Chunk k is written at edge t0+k+1.
- done=1 and busy=0 from edge t0+CHUNKS for exactly one cycle. Latency is CHUNKS cycles.
- Back-to-back: start held high in DONE re-accepts at edge t0+CHUNKS+1. Throughput is one op per CHUNKS+1 cycles.
- The adder path is combinational within a cycle: chunk mux, then adder, then registers. There is no internal adder pipelining.

## Test plan
Parameters WIDTH=8, CHUNKS=4, N=32.
- Reset: hold rst=1 with random inputs and toggling start -> all outputs 0, busy=0. Assert rst mid-RUN -> outputs 0 asynchronously, no done pulse; a following start completes normally.
- Carry ripple: a=0x000000FF, b=0x00000001, sub=0, start at edge t0 -> busy high t0..t0+3, done only in cycle t0+4, result=0x00000100, carry_out=0, overflow=0, zero=0.
- Signed overflow:
  - 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, carry_out=0.
  - 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
- Wrap and zero:
  - 0xFFFFFFFF + 0x00000001 -> result=0, carry_out=1, zero=1, overflow=0.
  - 5 - 5 (sub=1) -> result=0, zero=1, carry_out=1.
  - 3 - 5 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
- Handshake:
  - Pulse start again during RUN with different operands -> ignored; the first result is unaffected.
  - Hold start high through DONE -> second op accepted at t0+5, its done at t0+9.
  - Between done pulses, result and flags stay at the first op's values.
- Scoreboard: 1000 random {a, b, sub} ops with random idle gaps -> result, carry_out and overflow match the 33-bit reference model. done count equals accept count.
